bank_arb_resp_demux: RTL and testbench
======================================

BANK_ARB_RESP_DEMUX -- requirements
Module: bank_arb_resp_demux

Interface
REQ-001 SHALL have parameter NumIn, default 8: number of masters (address decoders) contending for this bank; at least 1.
REQ-002 SHALL have parameter ReqDataWidth, default 32: request payload width.
REQ-003 SHALL have parameter RespDataWidth, default 32: response payload width.
REQ-004 SHALL have parameter MaxOutstanding, default 2: depth of the in-order tag FIFO; at least 1.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all state rising-edge.
REQ-006 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port req_i, input, NumIn: per-master request.
REQ-008 SHALL have port data_i, input, NumIn x ReqDataWidth: per-master request payload.
REQ-009 SHALL have port gnt_o, output, NumIn: per-master grant.
REQ-010 SHALL have port vld_o, output, NumIn: per-master response valid.
REQ-011 SHALL have port rdata_o, output, NumIn x RespDataWidth: per-master response data.
REQ-012 SHALL have port req_o, output, 1: request to the bank.
REQ-013 SHALL have port data_o, output, ReqDataWidth: payload to the bank.
REQ-014 SHALL have port gnt_i, input, 1: bank grant.
REQ-015 SHALL have port vld_i, input, 1: bank response valid; minimum latency 1 cycle after handshake, variable thereafter, in order.
REQ-016 SHALL have port rdata_i, input, RespDataWidth: bank response data.

Function
REQ-017 SHALL select winner w combinationally by round-robin: first index with req_i set, scanning upward from rr_q and wrapping modulo NumIn.
REQ-018 SHALL drive req_o = (|req_i) AND NOT fifo_full, with no bypass when full, even if a pop occurs in the same cycle.
REQ-019 SHALL drive data_o = data_i[w]; data_o is don't-care when req_o=0.
REQ-020 SHALL drive gnt_o[w] = req_o AND gnt_i; all other gnt_o bits SHALL be 0, and gnt_o[i] SHALL never be 1 when req_i[i]=0.
REQ-021 SHALL treat handshake = req_o AND gnt_i; on handshake, w SHALL be pushed into the tag FIFO and rr_q SHALL become (w+1) mod NumIn.
REQ-022 SHALL hold rr_q when no handshake occurs, including when req_o=1 and gnt_i=0, so a stalled winner keeps priority.
REQ-023 SHALL keep the tag FIFO as a circular buffer with MaxOutstanding entries, width max(1, clog2(NumIn)) bits, read/write pointers wrapping modulo MaxOutstanding, and an occupancy counter 0..MaxOutstanding.
REQ-024 SHALL, when vld_i=1 and the FIFO is not empty, assert vld_o[head] for one cycle and pop the head.
REQ-025 SHALL drive vld_o = 0 and leave state unchanged when vld_i=1 with an empty FIFO; a simulation-only assertion SHALL flag this case.
REQ-026 SHALL drive rdata_o[i] = rdata_i for every i, broadcast; only vld_o qualifies ownership.
REQ-027 SHALL, on a simultaneous push and pop, update both pointers and leave occupancy unchanged.
REQ-028 SHALL, when NumIn=1, reduce w to 0, hold rr_q at 0, and otherwise behave identically.
REQ-029 SHALL have no combinational path from vld_i to req_o or gnt_o.

Reset
REQ-030 SHALL, on rst_ni low, asynchronously clear rr_q to 0, both FIFO pointers to 0 and occupancy to 0.
REQ-031 SHALL hold all outputs as follows during and immediately after reset: gnt_o=0, vld_o=0, and req_o = |req_i (FIFO empty).
REQ-032 SHALL discard all in-flight tags on reset mid-operation; later vld_i with an empty FIFO SHALL follow REQ-025.

Verification
REQ-033 SHALL cover fairness: NumIn=4, req_i=4'b1111 held, gnt_i=1, vld_i two cycles after each grant -> gnt_o sequence 0001, 0010, 0100, 1000, 0001.
REQ-034 SHALL cover a stall: req_i=4'b0110, gnt_i=0 for 3 cycles then 1 -> gnt_o=0 during the stall, then 0010; rr_q unchanged during the stall, then 2.
REQ-035 SHALL cover full back-pressure: MaxOutstanding=2, two handshakes with no vld_i -> req_o=0 with req_i non-zero; a vld_i pulse -> vld_o to the first winner, req_o=1 next cycle.
REQ-036 SHALL cover in-order routing: grants to masters 3 then 1, vld_i with rdata_i=0xA then 0xB -> vld_o[3] with rdata 0xA, then vld_o[1] with rdata 0xB.
REQ-037 SHALL cover simultaneous push and pop: occupancy 1 with handshake and vld_i in the same cycle -> occupancy stays 1, head equals the new winner.
REQ-038 SHALL cover reset mid-flight: 2 outstanding, rst_ni pulsed low -> occupancy 0, rr_q 0; following vld_i -> vld_o=0 and the assertion fires.

Source files
------------

// File: rtl/bank_arb_resp_demux_if.sv
// rtl/bank_arb_resp_demux_if.sv - master-side and bank-side signal bundle for the bank arbiter/demux
interface bank_arb_resp_demux_if #(
    parameter int NumIn         = 8,
    parameter int ReqDataWidth  = 32,
    parameter int RespDataWidth = 32
);
    logic [NumIn-1:0]                    req_i;
    logic [NumIn-1:0][ReqDataWidth-1:0]  data_i;
    logic [NumIn-1:0]                    gnt_o;
    logic [NumIn-1:0]                    vld_o;
    logic [NumIn-1:0][RespDataWidth-1:0] rdata_o;
    logic                                req_o;
    logic [ReqDataWidth-1:0]             data_o;
    logic                                gnt_i;
    logic                                vld_i;
    logic [RespDataWidth-1:0]            rdata_i;

    modport slave (
        input  req_i, data_i, gnt_i, vld_i, rdata_i,
        output gnt_o, vld_o, rdata_o, req_o, data_o
    );

    modport master (
        output req_i, data_i, gnt_i, vld_i, rdata_i,
        input  gnt_o, vld_o, rdata_o, req_o, data_o
    );
endinterface

// File: rtl/bank_arb_resp_demux.sv
// rtl/bank_arb_resp_demux.sv - round-robin bank arbiter with in-order tag FIFO routing responses back
module bank_arb_resp_demux #(
    parameter int NumIn          = 8,
    parameter int ReqDataWidth   = 32,
    parameter int RespDataWidth  = 32,
    parameter int MaxOutstanding = 2
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    bank_arb_resp_demux_if.slave bus
);
    localparam int TagW = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [TagW-1:0] rr_q;
    logic [TagW-1:0] win;
    logic [TagW-1:0] tag_mem [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [TagW-1:0] head;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // First requester at or above rr_q, wrapping; stays at 0 for a single master.
    always_comb begin
        logic            found;
        logic [TagW-1:0] idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NumIn; k++) begin
            idx = TagW'((int'(rr_q) + k) % NumIn);
            if (!found && bus.req_i[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign full  = (count_q == CntW'(MaxOutstanding));
    assign empty = (count_q == '0);
    assign head  = tag_mem[rd_ptr_q];

    // No bypass when full: a same-cycle pop does not free a slot for this cycle's request.
    assign bus.req_o  = (|bus.req_i) && !full;
    assign bus.data_o = bus.data_i[win];

    // Held off while in reset so no grant is issued without its tag being recorded.
    assign push = bus.req_o && bus.gnt_i && rst_ni;
    assign pop  = bus.vld_i && !empty && rst_ni;

    always_comb begin
        bus.gnt_o = '0;
        bus.vld_o = '0;
        bus.gnt_o[win]  = push;
        bus.vld_o[head] = pop;
        for (int i = 0; i < NumIn; i++) begin
            bus.rdata_o[i] = bus.rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                rr_q     <= (NumIn == 1) ? '0 : TagW'((int'(win) + 1) % NumIn);
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Tag storage needs no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= win;
        end
    end

    a_no_orphan_response : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(bus.vld_i && empty)
    ) else $warning("bank_arb_resp_demux: response arrived with no outstanding tag");
endmodule

// File: tb/tb_bank_arb_resp_demux.sv
// tb/tb_bank_arb_resp_demux.sv - scoreboard bench for bank_arb_resp_demux (4 masters, 2 outstanding)
module tb_bank_arb_resp_demux;
    localparam int N  = 4;
    localparam int DW = 32;

    localparam int K_REQ  = 0;
    localparam int K_RR   = 1;
    localparam int K_CNT  = 2;
    localparam int K_DATA = 3;

    typedef struct {
        int            cyc;
        logic [N-1:0]  bits;
        logic [DW-1:0] data;
    } ev_t;

    typedef struct {
        int            cyc;
        int            kind;
        logic [DW-1:0] val;
    } chk_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   cyc    = 0;
    bit   done   = 1'b0;
    bit   closed = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    ev_t  exp_gnt[$];
    ev_t  exp_vld[$];
    chk_t exp_chk[$];

    bank_arb_resp_demux_if #(.NumIn(N), .ReqDataWidth(DW), .RespDataWidth(DW)) bus ();

    bank_arb_resp_demux #(
        .NumIn(N), .ReqDataWidth(DW), .RespDataWidth(DW), .MaxOutstanding(2)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic exp_g(input logic [N-1:0] b);
        exp_gnt.push_back('{cyc, b, '0});
    endtask

    task automatic exp_v(input logic [N-1:0] b, input logic [DW-1:0] d);
        exp_vld.push_back('{cyc, b, d});
    endtask

    task automatic exp_c(input int kind, input logic [DW-1:0] v);
        exp_chk.push_back('{cyc, kind, v});
    endtask

    // Stimulus: directed vectors, expectations pushed for the cycle being driven.
    initial begin
        bus.req_i   = '0;
        bus.gnt_i   = 1'b0;
        bus.vld_i   = 1'b0;
        bus.rdata_i = '0;
        for (int k = 0; k < N; k++) bus.data_i[k] = 32'h100 + k;

        // reset: req_o follows |req_i, no grant even with gnt_i high
        tick(); bus.req_i = 4'b0101; bus.gnt_i = 1'b1;
        exp_c(K_REQ, 1); exp_c(K_RR, 0); exp_c(K_CNT, 0);
        tick(); exp_c(K_REQ, 1);
        tick(); rst_ni = 1'b1; bus.req_i = '0; bus.gnt_i = 1'b0;
        tick(); exp_c(K_REQ, 0);

        // fairness with responses two cycles after each grant
        tick(); bus.req_i = 4'b1111; bus.gnt_i = 1'b1; exp_g(4'b0001);
        tick(); exp_g(4'b0010);
        tick(); bus.vld_i = 1'b1; bus.rdata_i = 32'hA0; exp_v(4'b0001, 32'hA0); exp_c(K_REQ, 0);
        tick(); bus.rdata_i = 32'hA1; exp_v(4'b0010, 32'hA1); exp_g(4'b0100); exp_c(K_CNT, 1);
        tick(); bus.vld_i = 1'b0; exp_g(4'b1000); exp_c(K_CNT, 1);
        tick(); bus.vld_i = 1'b1; bus.rdata_i = 32'hA2; exp_v(4'b0100, 32'hA2); exp_c(K_REQ, 0);
        tick(); bus.rdata_i = 32'hA3; exp_v(4'b1000, 32'hA3); exp_g(4'b0001);
        tick(); bus.req_i = '0; bus.gnt_i = 1'b0; bus.vld_i = 1'b0; exp_c(K_RR, 1); exp_c(K_CNT, 1);
        tick(); bus.vld_i = 1'b1; bus.rdata_i = 32'hA4; exp_v(4'b0001, 32'hA4);
        tick(); bus.vld_i = 1'b0; exp_c(K_CNT, 0);

        // stall: winner keeps priority while gnt_i is low
        tick(); bus.req_i = 4'b0110; exp_c(K_REQ, 1); exp_c(K_RR, 1); exp_c(K_DATA, 32'h101);
        tick(); exp_c(K_RR, 1);
        tick(); exp_c(K_RR, 1);
        tick(); bus.gnt_i = 1'b1; exp_g(4'b0010);
        tick(); bus.req_i = '0; bus.gnt_i = 1'b0; exp_c(K_RR, 2); exp_c(K_CNT, 1);
        tick(); bus.vld_i = 1'b1; bus.rdata_i = 32'hB0; exp_v(4'b0010, 32'hB0);
        tick(); bus.vld_i = 1'b0; exp_c(K_CNT, 0);

        // in-order routing: masters 3 then 1
        tick(); bus.req_i = 4'b1010; bus.gnt_i = 1'b1; exp_g(4'b1000); exp_c(K_DATA, 32'h103);
        tick(); exp_g(4'b0010); exp_c(K_DATA, 32'h101);
        tick(); bus.req_i = '0; bus.gnt_i = 1'b0; bus.vld_i = 1'b1; bus.rdata_i = 32'hA;
        exp_v(4'b1000, 32'hA);
        tick(); bus.rdata_i = 32'hB; exp_v(4'b0010, 32'hB);
        tick(); bus.vld_i = 1'b0; exp_c(K_RR, 2); exp_c(K_CNT, 0);

        // full back-pressure, no bypass on the popping cycle
        tick(); bus.req_i = 4'b0001; bus.gnt_i = 1'b1; exp_g(4'b0001);
        tick(); exp_g(4'b0001);
        tick(); exp_c(K_REQ, 0); exp_c(K_CNT, 2);
        tick(); bus.vld_i = 1'b1; bus.rdata_i = 32'hC; exp_v(4'b0001, 32'hC); exp_c(K_REQ, 0);
        tick(); bus.vld_i = 1'b0; exp_c(K_REQ, 1); exp_g(4'b0001);
        tick(); bus.req_i = '0; bus.gnt_i = 1'b0; exp_c(K_CNT, 2);

        // reset with two tags in flight, then an orphan response
        tick(); rst_ni = 1'b0; exp_c(K_CNT, 0); exp_c(K_RR, 0);
        tick(); rst_ni = 1'b1;
        tick(); bus.vld_i = 1'b1; bus.rdata_i = 32'hD; exp_c(K_CNT, 0);
        tick(); bus.vld_i = 1'b0; exp_c(K_CNT, 0); exp_c(K_RR, 0);
        tick();
        tick();
        done = 1'b1;
    end

    // Monitor / scoreboard: all comparisons and the summary live here.
    ev_t           e;
    chk_t          c;
    logic [DW-1:0] act;
    bit            bad;

    always @(negedge clk_i) begin
        if (!closed) begin
            if (|bus.gnt_o || (exp_gnt.size() > 0 && exp_gnt[0].cyc <= cyc)) begin
                n_vec++;
                if (exp_gnt.size() == 0) begin
                    n_err++;
                    $display("FAIL gnt_o: got %b at cycle %0d, expected no grant", bus.gnt_o, cyc);
                end else begin
                    e = exp_gnt.pop_front();
                    if (e.cyc != cyc || e.bits != bus.gnt_o) begin
                        n_err++;
                        $display("FAIL gnt_o: got %b at cycle %0d, expected %b at cycle %0d",
                                 bus.gnt_o, cyc, e.bits, e.cyc);
                    end
                end
            end

            if (|bus.vld_o || (exp_vld.size() > 0 && exp_vld[0].cyc <= cyc)) begin
                n_vec++;
                if (exp_vld.size() == 0) begin
                    n_err++;
                    $display("FAIL vld_o: got %b at cycle %0d, expected no response", bus.vld_o, cyc);
                end else begin
                    e   = exp_vld.pop_front();
                    bad = (e.cyc != cyc) || (e.bits != bus.vld_o);
                    for (int i = 0; i < N; i++) if (bus.rdata_o[i] != e.data) bad = 1'b1;
                    if (bad) begin
                        n_err++;
                        $display("FAIL vld_o/rdata_o: got %b/%h at cycle %0d, expected %b/%h at cycle %0d",
                                 bus.vld_o, bus.rdata_o, cyc, e.bits, e.data, e.cyc);
                    end
                end
            end

            while (exp_chk.size() > 0 && exp_chk[0].cyc <= cyc) begin
                c = exp_chk.pop_front();
                case (c.kind)
                    K_REQ:   act = 32'(bus.req_o);
                    K_RR:    act = 32'(dut.rr_q);
                    K_CNT:   act = 32'(dut.count_q);
                    default: act = bus.data_o;
                endcase
                n_vec++;
                if (act != c.val) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h (cycle %0d)",
                             (c.kind == K_REQ) ? "req_o" : (c.kind == K_RR) ? "rr_q" :
                             (c.kind == K_CNT) ? "occupancy" : "data_o", act, c.val, cyc);
                end
            end

            if (!done && cyc > 1000) begin
                n_vec++;
                n_err++;
                $display("FAIL timeout: stimulus still running at cycle %0d, limit 1000", cyc);
                closed = 1'b1;
            end

            if (done) closed = 1'b1;

            if (closed) begin
                if (exp_gnt.size() + exp_vld.size() + exp_chk.size() != 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL leftover: %0d expectations never met, expected 0",
                             exp_gnt.size() + exp_vld.size() + exp_chk.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end
endmodule
